i2c_reg_rd_seq: RTL
===================

Name: i2c_reg_rd_seq

Overview:
Parametrised I2C register-read sequencer, next generation of the single-sensor read master.
- Sequence per request: START, slave address (W), sub-address, repeated START, slave address (R), 1..C_MAX_BYTES data reads (last byte NACKed), STOP.
- Drives the command interface of I2C_MSTR_CORE and returns read bytes plus completion/error status.
- Adds an optional free-running auto-poll timer and NACK error abort.

Parameters:
C_MAX_BYTES, 4, maximum data bytes per transaction (1..16).
C_NB_W, $clog2(C_MAX_BYTES+1), width of NBYTEs_i.
C_POLL_CYC, 0, auto-poll period in CK_i cycles; 0 disables auto-poll.

Ports:
CK_i  in  1  single clock.
XARST_i  in  1  reset; synchronous, active-low.
REQ_i  in  1  start-transaction pulse; sampled only in IDLE.
SLV_ADRs_i  in  7  7-bit slave address; latched on acceptance.
SUB_ADRs_i  in  8  register pointer; latched on acceptance.
NBYTEs_i  in  C_NB_W  bytes to read; latched on acceptance.
BUSY_o  out  1  high from acceptance until DONE_o cycle, inclusive.
DONE_o  out  1  one-cycle completion pulse.
ERR_o  out  1  NACK status of the last transaction; valid with DONE_o, held until next acceptance.
RX_DATs_o  out  8*C_MAX_BYTES  read bytes; byte k at [8k+7:8k].
CORE_REQ_o  out  1  one-cycle command strobe to core.
CORE_MODEs_o  out  3  command: 010 START, 000 WRITE, 001 READ+ACK, 011 READ+NACK, 100 STOP.
CORE_TX_DATs_o  out  8  write byte.
CORE_DONE_i  in  1  core command complete pulse.
CORE_RX_DATs_i  in  8  core read byte.
CORE_RX_DAT_LT_i  in  1  CORE_RX_DATs_i valid, coincident with CORE_DONE_i.
CORE_ERR_i  in  1  NACK on last write, coincident with CORE_DONE_i.

Behaviour:
- Reset (XARST_i low at a CK_i edge): all outputs 0, RX_DATs_o 0, state IDLE, poll counter 0. Applies mid-transaction; no STOP is issued.
- Acceptance: in IDLE, REQ_i=1 or a poll tick latches the inputs, asserts BUSY_o, and clears the shadow data register and the error flag. REQ_i while BUSY_o=1 is ignored, not queued.
- NBYTEs_i==0 is treated as 1. NBYTEs_i>C_MAX_BYTES is clamped to C_MAX_BYTES.
- Command handshake: each state drives CORE_MODEs_o/CORE_TX_DATs_o and asserts CORE_REQ_o for exactly one cycle on state entry. It then waits for CORE_DONE_i. Mode and TX data are held stable until the next strobe. CORE_DONE_i outside a wait is ignored.
- Latency: acceptance at edge t gives the START strobe at edge t+1. Each CORE_DONE_i at edge n gives the next strobe at edge n+1.
- States and transitions:
  - IDLE -> START -> WSA(TX={SLV,0}) -> WSUB(TX=SUB) -> RSTART(010) -> RSA(TX={SLV,1}) -> RD -> STOP -> FIN -> IDLE.
  - RD repeats N times. Mode is 001 for bytes 0..N-2 and 011 for byte N-1. A byte counter increments on each RD CORE_DONE_i.
  - RD: when CORE_RX_DAT_LT_i=1 with CORE_DONE_i, byte k is written into the shadow register at [8k+7:8k].
  - WSA, WSUB, RSA: CORE_ERR_i=1 with CORE_DONE_i sets the error flag and jumps to STOP; remaining phases are skipped. CORE_ERR_i in other states is ignored.
  - FIN: one cycle. Asserts DONE_o; copies the shadow register to RX_DATs_o (unread bytes 0, including on error); ERR_o=flag; BUSY_o drops the next cycle.
- RX_DATs_o changes only in the FIN cycle; it is stable otherwise.
- Auto-poll (C_POLL_CYC>0): the counter runs only while IDLE and clears on acceptance. On reaching C_POLL_CYC-1 it requests using the current inputs. If REQ_i and the tick coincide, a single transaction runs.

Test Plan:
- SLV=0x48, SUB=0x00, N=2; core model ACKs all, returns 0x19, 0x80 -> strobes 010,000(0x90),000(0x00),010,000(0x91),001,011,100; DONE_o one cycle; RX_DATs_o[15:0]=0x8019, ERR_o=0, upper bytes 0.
- Same request with the model NACKing WSA -> next strobe is 100 (STOP), no reads; DONE_o with ERR_o=1, RX_DATs_o=0. Repeat with the NACK on RSA -> identical outcome.
- N=0 then N=C_MAX_BYTES+3 -> exactly 1 and C_MAX_BYTES reads respectively; the final read always uses mode 011.
- REQ_i pulsed mid-transaction -> no effect on strobes; exactly one DONE_o; RX_DATs_o unchanged until FIN.
- C_POLL_CYC=50, no REQ_i -> START strobes spaced by transaction length plus 50 idle cycles. REQ_i on the tick cycle -> one transaction.
- XARST_i low for one cycle during RD -> next cycle all outputs 0, IDLE; a new REQ_i then starts a clean transaction from START.

Source files
------------

// File: rtl/i2c_reg_rd_seq_if.sv
// Command bus between the register-read sequencer and I2C_MSTR_CORE.
// master = sequencer side, slave = core side.
interface i2c_reg_rd_seq_if;
    logic       CORE_REQ_o;
    logic [2:0] CORE_MODEs_o;
    logic [7:0] CORE_TX_DATs_o;
    logic       CORE_DONE_i;
    logic [7:0] CORE_RX_DATs_i;
    logic       CORE_RX_DAT_LT_i;
    logic       CORE_ERR_i;

    modport master (
        output CORE_REQ_o,
        output CORE_MODEs_o,
        output CORE_TX_DATs_o,
        input  CORE_DONE_i,
        input  CORE_RX_DATs_i,
        input  CORE_RX_DAT_LT_i,
        input  CORE_ERR_i
    );

    modport slave (
        input  CORE_REQ_o,
        input  CORE_MODEs_o,
        input  CORE_TX_DATs_o,
        output CORE_DONE_i,
        output CORE_RX_DATs_i,
        output CORE_RX_DAT_LT_i,
        output CORE_ERR_i
    );
endinterface

// File: rtl/i2c_reg_rd_seq.sv
// I2C register-read sequencer: START, SLA+W, sub-address, Sr, SLA+R, N reads
// (last NACKed), STOP. Optional auto-poll timer and NACK abort.
module i2c_reg_rd_seq #(
    parameter int unsigned C_MAX_BYTES = 4,
    parameter int unsigned C_NB_W      = $clog2(C_MAX_BYTES + 1),
    parameter int unsigned C_POLL_CYC  = 0
) (
    input  logic                       CK_i,
    input  logic                       XARST_i,
    input  logic                       REQ_i,
    input  logic [6:0]                 SLV_ADRs_i,
    input  logic [7:0]                 SUB_ADRs_i,
    input  logic [C_NB_W-1:0]          NBYTEs_i,
    output logic                       BUSY_o,
    output logic                       DONE_o,
    output logic                       ERR_o,
    output logic [8*C_MAX_BYTES-1:0]   RX_DATs_o,
    i2c_reg_rd_seq_if.master           core_if
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WSA,
        ST_WSUB,
        ST_RSTART,
        ST_RSA,
        ST_RD,
        ST_STOP,
        ST_FIN
    } state_t;

    localparam logic [2:0] MODE_WRITE = 3'b000;
    localparam logic [2:0] MODE_RDACK = 3'b001;
    localparam logic [2:0] MODE_START = 3'b010;
    localparam logic [2:0] MODE_RDNAK = 3'b011;
    localparam logic [2:0] MODE_STOP  = 3'b100;

    localparam logic [C_NB_W-1:0] MAX_N = C_NB_W'(C_MAX_BYTES);
    localparam logic [C_NB_W-1:0] ONE_N = C_NB_W'(1);

    localparam int unsigned       POLL_W    = (C_POLL_CYC > 1) ? $clog2(C_POLL_CYC) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'((C_POLL_CYC > 0) ? C_POLL_CYC - 1 : 0);
    localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);

    state_t                     state_q;
    logic [6:0]                 slv_q;
    logic [7:0]                 sub_q;
    logic [C_NB_W-1:0]          n_q;
    logic [C_NB_W-1:0]          cnt_q;
    logic [8*C_MAX_BYTES-1:0]   shadow_q;
    logic                       nack_q;
    logic [POLL_W-1:0]          poll_q;

    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;
    logic [8*C_MAX_BYTES-1:0]   rx_q;
    logic                       core_req_q;
    logic [2:0]                 mode_q;
    logic [7:0]                 tx_q;

    logic [C_NB_W-1:0]          nbytes_d;
    logic [C_NB_W-1:0]          cnt_d;
    logic                       poll_tick;
    logic                       accept;
    logic                       core_done;
    logic                       last_rd;
    logic                       next_last_rd;

    // Zero-length requests still perform one read; oversize ones are clamped.
    always_comb begin
        nbytes_d = NBYTEs_i;
        if (NBYTEs_i == '0) begin
            nbytes_d = ONE_N;
        end else if (NBYTEs_i > MAX_N) begin
            nbytes_d = MAX_N;
        end
    end

    assign poll_tick    = (C_POLL_CYC > 0) && (state_q == ST_IDLE) && (poll_q == POLL_LAST);
    assign accept       = (state_q == ST_IDLE) && (REQ_i || poll_tick);
    // A completion arriving in the strobe cycle itself belongs to no command.
    assign core_done    = core_if.CORE_DONE_i && !core_req_q;
    assign cnt_d        = cnt_q + ONE_N;
    assign last_rd      = (cnt_q == n_q - ONE_N);
    assign next_last_rd = (cnt_d == n_q - ONE_N);

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            state_q    <= ST_IDLE;
            slv_q      <= '0;
            sub_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            nack_q     <= 1'b0;
            poll_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_q       <= '0;
            core_req_q <= 1'b0;
            mode_q     <= '0;
            tx_q       <= '0;
        end else begin
            core_req_q <= 1'b0;
            done_q     <= 1'b0;

            if (accept) begin
                poll_q <= '0;
            end else if ((C_POLL_CYC > 0) && (state_q == ST_IDLE)) begin
                poll_q <= poll_q + POLL_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        slv_q      <= SLV_ADRs_i;
                        sub_q      <= SUB_ADRs_i;
                        n_q        <= nbytes_d;
                        cnt_q      <= '0;
                        shadow_q   <= '0;
                        nack_q     <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                        core_req_q <= 1'b1;
                        mode_q     <= MODE_START;
                    end
                end

                ST_START: begin
                    if (core_done) begin
                        state_q    <= ST_WSA;
                        core_req_q <= 1'b1;
                        mode_q     <= MODE_WRITE;
                        tx_q       <= {slv_q, 1'b0};
                    end
                end

                ST_WSA: begin
                    if (core_done) begin
                        core_req_q <= 1'b1;
                        if (core_if.CORE_ERR_i) begin
                            nack_q  <= 1'b1;
                            state_q <= ST_STOP;
                            mode_q  <= MODE_STOP;
                        end else begin
                            state_q <= ST_WSUB;
                            mode_q  <= MODE_WRITE;
                            tx_q    <= sub_q;
                        end
                    end
                end

                ST_WSUB: begin
                    if (core_done) begin
                        core_req_q <= 1'b1;
                        if (core_if.CORE_ERR_i) begin
                            nack_q  <= 1'b1;
                            state_q <= ST_STOP;
                            mode_q  <= MODE_STOP;
                        end else begin
                            state_q <= ST_RSTART;
                            mode_q  <= MODE_START;
                        end
                    end
                end

                ST_RSTART: begin
                    if (core_done) begin
                        state_q    <= ST_RSA;
                        core_req_q <= 1'b1;
                        mode_q     <= MODE_WRITE;
                        tx_q       <= {slv_q, 1'b1};
                    end
                end

                ST_RSA: begin
                    if (core_done) begin
                        core_req_q <= 1'b1;
                        if (core_if.CORE_ERR_i) begin
                            nack_q  <= 1'b1;
                            state_q <= ST_STOP;
                            mode_q  <= MODE_STOP;
                        end else begin
                            state_q <= ST_RD;
                            mode_q  <= (n_q == ONE_N) ? MODE_RDNAK : MODE_RDACK;
                        end
                    end
                end

                ST_RD: begin
                    if (core_done) begin
                        if (core_if.CORE_RX_DAT_LT_i) begin
                            for (int unsigned k = 0; k < C_MAX_BYTES; k++) begin
                                if (cnt_q == C_NB_W'(k)) begin
                                    shadow_q[8*k +: 8] <= core_if.CORE_RX_DATs_i;
                                end
                            end
                        end
                        cnt_q      <= cnt_d;
                        core_req_q <= 1'b1;
                        if (last_rd) begin
                            state_q <= ST_STOP;
                            mode_q  <= MODE_STOP;
                        end else begin
                            mode_q  <= next_last_rd ? MODE_RDNAK : MODE_RDACK;
                        end
                    end
                end

                ST_STOP: begin
                    if (core_done) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        rx_q    <= shadow_q;
                        err_q   <= nack_q;
                    end
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY_o                 = busy_q;
    assign DONE_o                 = done_q;
    assign ERR_o                  = err_q;
    assign RX_DATs_o              = rx_q;
    assign core_if.CORE_REQ_o     = core_req_q;
    assign core_if.CORE_MODEs_o   = mode_q;
    assign core_if.CORE_TX_DATs_o = tx_q;

endmodule
